if_fetch_stage: RTL

- Instruction-fetch stage of the five-stage pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues one instruction-memory request at a time over a valid/ready request and rvalid response handshake.
- Presents PC and instruction with a valid flag to IF/ID.
- Honours the hazard-unit stall (PCWrite) and EX-stage branch/jump redirects; discards responses made stale by a redirect.

---
 rtl/if_fetch_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and single-outstanding instruction fetch feeding IF/ID.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR and pulse fetch_misalign.
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
`ifdef FETCH_MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        if_valid,
  output logic        IF_flush,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_out_q;
  logic [31:0] inst_q;
  logic        drop_q;
  logic [31:0] redir_pc_d;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  always_comb begin
    redir_pc_d = (branch_target[1:0] != 2'b00) ? TRAP_VECTOR : branch_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= branch_taken && (branch_target[1:0] != 2'b00);
    end
  end

  assign fetch_misalign = misalign_q;
`else
  always_comb begin
    redir_pc_d = branch_target & 32'hFFFF_FFFC;
  end

  assign fetch_misalign = 1'b0;
`endif

  // drop_q marks an accepted request whose response must be thrown away
  // because a redirect arrived after it left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      inst_q   <= 32'h0;
      drop_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            state_q <= S_WAIT;
            drop_q  <= branch_taken;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop_q <= 1'b0;
            if (drop_q || branch_taken) begin
              state_q <= S_FETCH;
            end else begin
              inst_q   <= imem_rdata;
              pc_out_q <= pc_q;
              state_q  <= S_VALID;
            end
          end else if (branch_taken) begin
            drop_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (branch_taken || PCWrite) begin
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase

      if (branch_taken) begin
        pc_q <= redir_pc_d;
      end else if (state_q == S_VALID && PCWrite) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign if_valid    = (state_q == S_VALID);
  assign PC          = pc_out_q;
  assign instruction = inst_q;
  assign IF_flush    = branch_taken;

endmodule

`default_nettype wire
